// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data memory controller:
// FSM state type, wait counter width and default parameter values.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 4;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_DEPTH       = 64;
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_WAIT_CYCLES = 4;

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: DEPTH x DATA_W words, synchronous write, combinational read.
// Contents are intentionally not reset.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory controller with fixed wait states; freezes the pipeline until the access completes.
// Optional DMEM_RANGE_CHECK_EN: out-of-window accesses are suppressed and flagged on err.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              freeze,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q, live_idx, eff_idx;
    logic [DATA_W-1:0] wdata_q, eff_wdata, arr_rdata;
    logic              wr_q, eff_wr;
    logic              req, accept, enter_done, arr_we, oor_eff;

    assign req      = mem_r_en | mem_w_en;
    assign accept   = (state_q == IDLE) && req;
    assign live_idx = IDX_W'((addr - 32'(BASE_ADDR)) >> 2);

    // With zero wait states the access completes on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    assign eff_idx   = (state_q == IDLE) ? live_idx : idx_q;
    assign eff_wdata = (state_q == IDLE) ? wdata    : wdata_q;
    assign eff_wr    = (state_q == IDLE) ? mem_w_en : wr_q;

    assign enter_done = (state_q == IDLE) ? (req && (WAIT_CYCLES == 0))
                                          : ((state_q == BUSY) && (cnt_q == '0));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = (WAIT_CYCLES == 0) ? DONE : BUSY;
            BUSY: if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(WAIT_CYCLES - 1);
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            idx_q   <= live_idx;
            wdata_q <= wdata;
            wr_q    <= mem_w_en;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic oor_live, oor_q;

    assign oor_live = (addr < BASE_ADDR) ||
                      ({1'b0, addr} >= (33'(BASE_ADDR) + 33'(4 * DEPTH)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else if (accept) begin
            oor_q <= oor_live;
        end
    end

    assign oor_eff = (state_q == IDLE) ? oor_live : oor_q;
    assign err     = (state_q == DONE) && oor_q;
`else
    assign oor_eff = 1'b0;
    assign err     = 1'b0;
`endif

    assign arr_we = enter_done && eff_wr && !oor_eff && !rst;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (eff_idx),
        .wdata (eff_wdata),
        .rdata (arr_rdata)
    );

    // rdata only moves on read completion; writes and combined r/w leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (enter_done && !eff_wr) begin
            rdata <= oor_eff ? '0 : arr_rdata;
        end
    end

    assign ready  = (state_q == DONE);
    assign freeze = !rst && (accept || (state_q == BUSY));

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed self-checking bench for dmem_wait_ctrl: a 4-wait-state instance and a 0-wait-state instance.
module tb_dmem_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_a, w_a, r_b, w_b;
    logic [31:0] addr_a, addr_b, wd_a, wd_b;
    logic [31:0] rd_a, rd_b;
    logic        rdy_a, rdy_b, fz_a, fz_b, err_a, err_b;

    int compared   = 0;
    int mismatched = 0;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [31:0] EXP_1024 = 32'h0000_0BAD;
    localparam logic        EXP_ERR  = 1'b1;
`else
    localparam logic [31:0] EXP_1024 = 32'h0000_CAFE;
    localparam logic        EXP_ERR  = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_wait_ctrl #(
        .DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .mem_r_en(r_a), .mem_w_en(w_a), .addr(addr_a),
        .wdata(wd_a), .rdata(rd_a), .ready(rdy_a), .freeze(fz_a), .err(err_a)
    );

    dmem_wait_ctrl #(
        .DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r_b), .mem_w_en(w_b), .addr(addr_b),
        .wdata(wd_b), .rdata(rd_b), .ready(rdy_b), .freeze(fz_b), .err(err_b)
    );

    // Presents one request (held like a frozen pipeline) and releases it on ready.
    // Cycle 1 is the request cycle; outputs are sampled 1 time unit after each falling edge.
    task automatic access(input bit sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int fz, output int rdy_at, output int rdy_n,
                          output logic err_seen, output logic [31:0] rd);
        @(negedge clk);
        if (sel) begin r_b = r; w_b = w; addr_b = a; wd_b = d; end
        else     begin r_a = r; w_a = w; addr_a = a; wd_a = d; end
        fz = 0; rdy_at = 0; rdy_n = 0; err_seen = 1'b0; rd = 'x;
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (sel ? fz_b : fz_a) fz++;
            if (sel ? rdy_b : rdy_a) begin
                rdy_n++;
                if (rdy_at == 0) begin
                    rdy_at = c;
                    rd = sel ? rd_b : rd_a;
                end
                err_seen = err_seen | (sel ? err_b : err_a);
                if (sel) begin r_b = 1'b0; w_b = 1'b0; end
                else     begin r_a = 1'b0; w_a = 1'b0; end
            end
            @(negedge clk);
        end
        r_a = 1'b0; w_a = 1'b0; r_b = 1'b0; w_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r_a = 1'b1; w_b = 1'b1; addr_a = 32'd1024; addr_b = 32'd1024;
        #1;
        compared++; if (fz_a !== 1'b0) begin mismatched++; $display("FAIL rst_freeze: got %b expected 0", fz_a); end
        compared++; if (rdy_a !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b expected 0", rdy_a); end
        compared++; if (rd_a !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h expected 0", rd_a); end
        compared++; if (err_a !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b expected 0", err_a); end
        compared++; if (fz_b !== 1'b0) begin mismatched++; $display("FAIL rst_freeze0: got %b expected 0", fz_b); end
        compared++; if (rd_b !== 32'h0) begin mismatched++; $display("FAIL rst_rdata0: got %h expected 0", rd_b); end
        r_a = 1'b0; w_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int fz, at, n; logic e; logic [31:0] rd;
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, fz, at, n, e, rd);
        compared++; if (fz != 5) begin mismatched++; $display("FAIL wr_freeze: got %0d expected 5", fz); end
        compared++; if (at != 6) begin mismatched++; $display("FAIL wr_ready_cycle: got %0d expected 6", at); end
        compared++; if (n != 1) begin mismatched++; $display("FAIL wr_ready_count: got %0d expected 1", n); end
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL wr_rdata_kept: got %h expected 0", rd); end
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, fz, at, n, e, rd);
        compared++; if (fz != 5) begin mismatched++; $display("FAIL rd_freeze: got %0d expected 5", fz); end
        compared++; if (at != 6) begin mismatched++; $display("FAIL rd_ready_cycle: got %0d expected 6", at); end
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL rd_err: got %b expected 0", e); end
    endtask

    task automatic test_wait0();
        int fz, at, n; logic e; logic [31:0] rd;
        access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0000A5A5, fz, at, n, e, rd);
        compared++; if (fz != 1) begin mismatched++; $display("FAIL w0_wr_freeze: got %0d expected 1", fz); end
        compared++; if (at != 2) begin mismatched++; $display("FAIL w0_wr_ready_cycle: got %0d expected 2", at); end
        access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, fz, at, n, e, rd);
        compared++; if (fz != 1) begin mismatched++; $display("FAIL w0_rd_freeze: got %0d expected 1", fz); end
        compared++; if (at != 2) begin mismatched++; $display("FAIL w0_rd_ready_cycle: got %0d expected 2", at); end
        compared++; if (n != 1) begin mismatched++; $display("FAIL w0_rd_ready_count: got %0d expected 1", n); end
        compared++; if (rd !== 32'h0000A5A5) begin mismatched++; $display("FAIL w0_rd_data: got %h expected 0000a5a5", rd); end
    endtask

    task automatic test_both_en();
        int fz, at, n; logic e; logic [31:0] rd;
        access(1'b0, 1'b1, 1'b1, 32'd1032, 32'h5, fz, at, n, e, rd);
        compared++; if (at != 6) begin mismatched++; $display("FAIL both_ready_cycle: got %0d expected 6", at); end
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL both_rdata_kept: got %h expected deadbeef", rd); end
        access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, fz, at, n, e, rd);
        compared++; if (rd !== 32'h5) begin mismatched++; $display("FAIL both_readback: got %h expected 00000005", rd); end
    endtask

    task automatic test_reset_abort();
        int fz, at, n; logic e; logic [31:0] rd;
        access(1'b0, 1'b0, 1'b1, 32'd1040, 32'h1111, fz, at, n, e, rd);
        @(negedge clk);
        w_a = 1'b1; addr_a = 32'd1040; wd_a = 32'h1234;
        repeat (3) @(negedge clk);
        #1;
        compared++; if (fz_a !== 1'b1) begin mismatched++; $display("FAIL abort_busy: got %b expected 1", fz_a); end
        rst = 1'b1;
        #1;
        compared++; if (fz_a !== 1'b0) begin mismatched++; $display("FAIL abort_freeze: got %b expected 0", fz_a); end
        compared++; if (rdy_a !== 1'b0) begin mismatched++; $display("FAIL abort_ready: got %b expected 0", rdy_a); end
        compared++; if (rd_a !== 32'h0) begin mismatched++; $display("FAIL abort_rdata: got %h expected 0", rd_a); end
        w_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b1, 1'b0, 32'd1040, 32'h0, fz, at, n, e, rd);
        compared++; if (rd !== 32'h1111) begin mismatched++; $display("FAIL abort_old_value: got %h expected 00001111", rd); end
        compared++; if (at != 6) begin mismatched++; $display("FAIL abort_recover_ready: got %0d expected 6", at); end
    endtask

    task automatic test_range();
        int fz, at, n; logic e; logic [31:0] rd;
        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0BAD, fz, at, n, e, rd);
        access(1'b0, 1'b0, 1'b1, 32'd1280, 32'hCAFE, fz, at, n, e, rd);
        compared++; if (at != 6) begin mismatched++; $display("FAIL range_ready_cycle: got %0d expected 6", at); end
        compared++; if (e !== EXP_ERR) begin mismatched++; $display("FAIL range_err: got %b expected %b", e, EXP_ERR); end
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, fz, at, n, e, rd);
        compared++; if (rd !== EXP_1024) begin mismatched++; $display("FAIL range_word0: got %h expected %h", rd, EXP_1024); end
`ifdef DMEM_RANGE_CHECK_EN
        access(1'b0, 1'b1, 1'b0, 32'd1280, 32'h0, fz, at, n, e, rd);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL range_oor_read: got %h expected 0", rd); end
        compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL range_oor_read_err: got %b expected 1", e); end
`else
        access(1'b0, 1'b1, 1'b0, 32'd1030, 32'h0, fz, at, n, e, rd);
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL range_lowbits: got %h expected deadbeef", rd); end
`endif
    endtask

    task automatic test_back_to_back();
        int n = 0, at1 = 0, at2 = 0;
        logic fz_after = 1'b0;
        logic [31:0] rd1 = 'x, rd2 = 'x;
        @(negedge clk);
        r_a = 1'b1; w_a = 1'b0; addr_a = 32'd1024;
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (at1 != 0 && c == at1 + 1) fz_after = fz_a & ~rdy_a;
            if (rdy_a) begin
                n++;
                if (n == 1) begin at1 = c; rd1 = rd_a; addr_a = 32'd1028; end
                else if (n == 2) begin at2 = c; rd2 = rd_a; r_a = 1'b0; end
            end
            @(negedge clk);
        end
        r_a = 1'b0;
        compared++; if (n != 2) begin mismatched++; $display("FAIL b2b_ready_count: got %0d expected 2", n); end
        compared++; if (at1 != 6) begin mismatched++; $display("FAIL b2b_first_cycle: got %0d expected 6", at1); end
        compared++; if (at2 != 12) begin mismatched++; $display("FAIL b2b_second_cycle: got %0d expected 12", at2); end
        compared++; if (fz_after !== 1'b1) begin mismatched++; $display("FAIL b2b_idle_between: got %b expected 1", fz_after); end
        compared++; if (rd1 !== EXP_1024) begin mismatched++; $display("FAIL b2b_first_data: got %h expected %h", rd1, EXP_1024); end
        compared++; if (rd2 !== 32'hDEADBEEF) begin mismatched++; $display("FAIL b2b_second_data: got %h expected deadbeef", rd2); end
    endtask

    initial begin
        rst = 1'b1;
        r_a = 1'b0; w_a = 1'b0; r_b = 1'b0; w_b = 1'b0;
        addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_wait0();
        test_both_en();
        test_reset_abort();
        test_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
